// File: rtl/simon_pkg.sv
// Shared types and sizing for the Simon game blocks: sequencer state encoding,
// level/memory widths and the colour index width.
package simon_pkg;

    localparam int LEVEL_W   = 4;
    localparam int MAX_LEVEL = 10;
    localparam int NUM_LEDS  = 4;
    localparam int IDX_W     = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        ON        = 3'd3,
        OFF       = 3'd4,
        FINISH    = 3'd5,
        HOLD      = 3'd6
    } blink_state_t;

    function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lvl);
        return (lvl > LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : lvl;
    endfunction

endpackage

// File: rtl/blink_sequencer_if.sv
// Sequence memory read port: strobe and address out, colour index back one
// cycle after the strobe.
interface blink_sequencer_if;
    import simon_pkg::*;

    logic               mem_rd_en;
    logic [LEVEL_W-1:0] mem_addr;
    logic [IDX_W-1:0]   mem_data;

    modport master (output mem_rd_en, output mem_addr, input mem_data);
    modport slave  (input mem_rd_en, input mem_addr, output mem_data);

endinterface

// File: rtl/blink_sequencer_led_decoder.sv
// Colour index to one-hot LED drive with enable; also usable for button echo.
module led_decoder #(
    parameter int IDX_W    = 2,
    parameter int NUM_LEDS = 4
) (
    input  logic [IDX_W-1:0]    i_idx,
    input  logic                i_en,
    output logic [NUM_LEDS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/blink_sequencer.sv
// Plays the stored sequence on the LEDs for the current level, then pulses
// blinker_done. Optional macro BLINK_SPEEDUP_EN shortens the on-time at higher levels.
module blink_sequencer
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEVEL_W-1:0]   level,
    blink_sequencer_if.master    mem,
    output logic [NUM_LEDS-1:0]  led,
    output logic                 busy,
    output logic                 blinker_done
);

    localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    blink_state_t       r_state, w_state_nxt;
    logic [LEVEL_W-1:0] r_idx, w_idx_nxt;
    logic [LEVEL_W-1:0] r_len, w_len_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_colour, w_colour_nxt;
    logic [LEVEL_W-1:0] w_level_clamped;
    logic [CNT_W-1:0]   w_on_last;
    logic               w_last;
    logic               w_led_en;

`ifdef BLINK_SPEEDUP_EN
    // On-time halves every four levels, never below one cycle.
    logic [31:0] w_on_eff;
    always_comb begin
        w_on_eff = 32'(ON_CYCLES) >> r_len[LEVEL_W-1:2];
        if (w_on_eff == 32'd0) begin
            w_on_eff = 32'd1;
        end
    end
    assign w_on_last = CNT_W'(w_on_eff - 32'd1);
`else
    assign w_on_last = CNT_W'(ON_CYCLES - 1);
`endif

    assign w_level_clamped = clamp_level(level);
    assign w_last          = (r_idx == r_len - LEVEL_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_colour <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_len    <= w_len_nxt;
            r_cnt    <= w_cnt_nxt;
            r_colour <= w_colour_nxt;
        end
    end

    // Dropping start anywhere in FETCH..OFF abandons playback without a done pulse.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_len_nxt    = r_len;
        w_cnt_nxt    = r_cnt;
        w_colour_nxt = r_colour;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_len_nxt   = w_level_clamped;
                    w_idx_nxt   = '0;
                    w_state_nxt = (w_level_clamped == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                w_state_nxt = start ? WAIT_DATA : IDLE;
            end
            WAIT_DATA: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_colour_nxt = mem.mem_data;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ON;
                end
            end
            ON: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == w_on_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = OFF;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            OFF: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_W'(OFF_CYCLES - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_last) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_idx_nxt   = r_idx + LEVEL_W'(1);
                        w_state_nxt = FETCH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            FINISH: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mem.mem_rd_en = (r_state == FETCH);
    assign mem.mem_addr  = r_idx;
    assign busy          = (r_state != IDLE);
    assign blinker_done  = (r_state == FINISH);
    assign w_led_en      = (r_state == ON);

    led_decoder #(
        .IDX_W    (IDX_W),
        .NUM_LEDS (NUM_LEDS)
    ) u_led_decoder (
        .i_idx    (r_colour),
        .i_en     (w_led_en),
        .o_onehot (led)
    );

endmodule
